mem_access_unit: RTL and testbench

- MEM-stage load/store controller for the 5-stage MIPS pipeline. It sits directly downstream of the datapath's EX/MEM register.
- Consumes the ALU address and the store data; produces the load data that feeds the MEM/WB readdata register.
- Drives a variable-latency req/ack data bus. Generates byte enables for sub-word accesses and does load alignment with sign/zero extension.
- Raises stallM to the hazard unit while an access is outstanding.

---
 rtl/mem_access_unit.sv | 182 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit -- MEM-stage load/store controller for the 5-stage MIPS pipeline.
//
// Sits downstream of the EX/MEM register. It turns a load/store in the MEM stage
// into one transaction on a variable-latency req/ack data bus. It generates byte lane
// enables and lane-replicated store data, and aligns and extends the returned load
// data. While the access is outstanding it holds the pipeline through stallM.
//
// Ports
//   clk, rst     clock, asynchronous active-high reset
//   memreadM     MEM-stage instruction is a load (wins if memwriteM is also set)
//   memwriteM    MEM-stage instruction is a store
//   sizeM        00 byte, 01 half, 10/11 word
//   signedM      sign-extend (1) or zero-extend (0) sub-word loads
//   addrM        byte address from the ALU
//   wdataM       right-justified store data
//   readdataM    aligned, extended load data; holds until the next completed load
//   stallM       pipeline hold while an access is in progress
//   misalignM    combinational address exception
//   bus_err      one-cycle flag that the access was aborted by timeout
//   bus_req/bus_we/bus_addr/bus_be/bus_wdata   registered bus request side
//   bus_ack/bus_rdata                          bus completion pulse and read word
//
// Optional feature: define MEM_TIMEOUT_EN to abort a bus cycle after TIMEOUT_CYCLES
// BUSY cycles without bus_ack. Without it, BUSY waits indefinitely and bus_err is 0.
`timescale 1ns/1ps

module mem_access_unit #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memreadM,
  input  logic              memwriteM,
  input  logic [1:0]        sizeM,
  input  logic              signedM,
  input  logic [ADDR_W-1:0] addrM,
  input  logic [31:0]       wdataM,
  output logic [31:0]       readdataM,
  output logic              stallM,
  output logic              misalignM,
  output logic              bus_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} stateT;

  stateT       state, stateNext;
  logic        acc, szByte, szHalf, szWord;
  logic        startAcc, startIdle, ackHit, timeoutHit;
  logic [3:0]  beNext;
  logic [1:0]  sizeL, laneL;
  logic        signedL;

  if (TIMEOUT_CYCLES < 1) begin : gBadTimeout
    $error("mem_access_unit: TIMEOUT_CYCLES must be at least 1");
  end

  // Pick the addressed byte/half out of the bus word and extend it.
  function automatic logic [31:0] extractLoad(input logic [31:0] w, input logic [1:0] sz,
                                              input logic sgn, input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    if (sz[1])      return w;
    else if (sz[0]) return {{16{sgn & h[15]}}, h};
    else            return {{24{sgn & b[7]}}, b};
  endfunction

  // Replicate the store data onto every lane so the enabled lanes carry it.
  function automatic logic [31:0] replicateStore(input logic [31:0] d, input logic [1:0] sz);
    if (sz[1])      return d;
    else if (sz[0]) return {2{d[15:0]}};
    else            return {4{d[7:0]}};
  endfunction

  assign acc    = memreadM | memwriteM;
  assign szWord = sizeM[1];
  assign szHalf = (sizeM == 2'b01);
  assign szByte = (sizeM == 2'b00);

  assign misalignM = acc & ((szHalf & addrM[0]) | (szWord & (addrM[1:0] != 2'b00)));
  assign startAcc  = acc & ~misalignM;
  assign startIdle = (state == IDLE) & startAcc;
  assign ackHit    = (state == BUSY) & bus_ack;

  always_comb begin
    beNext = 4'b1111;
    if (szByte)      beNext = 4'b0001 << addrM[1:0];
    else if (szHalf) beNext = addrM[1] ? 4'b1100 : 4'b0011;
  end

  // Next state and the Mealy stall output. DONE always returns to IDLE and never
  // restarts, even though the same instruction still presents acc that cycle.
  always_comb begin
    stateNext = state;
    stallM    = 1'b0;
    case (state)
      IDLE: begin
        stallM = startAcc;
        if (startAcc) stateNext = BUSY;
      end
      BUSY: begin
        stallM = 1'b1;
        if (bus_ack || timeoutHit) stateNext = DONE;
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= 4'b0000;
      bus_wdata <= 32'h0;
      sizeL     <= 2'b00;
      signedL   <= 1'b0;
      laneL     <= 2'b00;
      readdataM <= 32'h0;
    end else begin
      state <= stateNext;

      // Request side is captured once and held for the whole bus cycle.
      if (startIdle) begin
        bus_req   <= 1'b1;
        bus_we    <= memwriteM & ~memreadM;
        bus_addr  <= {addrM[ADDR_W-1:2], 2'b00};
        bus_be    <= beNext;
        bus_wdata <= replicateStore(wdataM, sizeM);
        sizeL     <= sizeM;
        signedL   <= signedM;
        laneL     <= addrM[1:0];
      end else if (ackHit || timeoutHit) begin
        bus_req <= 1'b0;
      end

      // readdataM is the load register: updated only by a completed load or an abort.
      if (ackHit && !bus_we)
        readdataM <= extractLoad(bus_rdata, sizeL, signedL, laneL);
      else if (timeoutHit)
        readdataM <= 32'h0;
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int TO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [TO_W-1:0] toCnt;

  // toCnt counts completed ack-less BUSY cycles, so the abort fires in the
  // TIMEOUT_CYCLES-th BUSY cycle. An ack in that same cycle takes precedence.
  assign timeoutHit = (state == BUSY) & ~bus_ack & (toCnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      toCnt   <= '0;
      bus_err <= 1'b0;
    end else begin
      bus_err <= timeoutHit;
      if (startIdle)
        toCnt <= '0;
      else if (state == BUSY && !bus_ack)
        toCnt <= toCnt + 1'b1;
    end
  end
`else
  assign timeoutHit = 1'b0;
  assign bus_err    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases followed by randomized
// loads/stores with random bus wait states, all checked against an arithmetic model.
`timescale 1ns/1ps

module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        memreadM, memwriteM, signedM;
  logic [1:0]  sizeM;
  logic [31:0] addrM, wdataM;
  logic [31:0] readdataM;
  logic        stallM, misalignM, bus_err;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int          nCompared = 0;
  int          nMismatched = 0;
  int          expTxn = 0;
  int          reqRises = 0;
  logic        reqPrev = 1'b0;
  logic [31:0] expRd;

  mem_access_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .memreadM(memreadM), .memwriteM(memwriteM), .sizeM(sizeM), .signedM(signedM),
    .addrM(addrM), .wdataM(wdataM), .readdataM(readdataM),
    .stallM(stallM), .misalignM(misalignM), .bus_err(bus_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  // Counts distinct bus transactions (rising edges of bus_req).
  always @(negedge clk) begin
    if (bus_req && !reqPrev) reqRises <= reqRises + 1;
    reqPrev <= bus_req;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---- reference model: access described by its byte count and offset ----
  function automatic int nBytes(input logic [1:0] sz);
    return sz[1] ? 4 : (sz[0] ? 2 : 1);
  endfunction

  function automatic logic [3:0] modelBe(input logic [1:0] sz, input logic [31:0] addr);
    int n, off;
    n   = nBytes(sz);
    off = int'(addr[1:0]);
    return 4'(((1 << n) - 1) << off);
  endfunction

  function automatic logic [31:0] modelWdata(input logic [1:0] sz, input logic [31:0] w);
    case (nBytes(sz))
      1:       return (w & 32'h0000_00FF) * 32'h0101_0101;
      2:       return (w & 32'h0000_FFFF) * 32'h0001_0001;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] modelLoad(input logic [31:0] rdata, input logic [1:0] sz,
                                            input logic sg, input logic [31:0] addr);
    int n;
    logic [31:0] v, mask;
    n = nBytes(sz);
    v = rdata >> (8 * int'(addr[1:0]));
    if (n < 4) begin
      mask = (32'h1 << (8 * n)) - 32'h1;
      v = v & mask;
      if (sg && v[8*n-1]) v = v | ~mask;
    end
    return v;
  endfunction

  // Presents one MEM-stage instruction and plays the bus responder with 'waits'
  // wait states; returns once the pipeline has advanced past the instruction.
  task automatic doAccess(input logic rd, input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int waits);
    int  n, stallCnt, reqCycles;
    bit  mis, done;
    n         = nBytes(sz);
    mis       = (rd || wr) && ((addr % n) != 0);
    stallCnt  = 0;
    reqCycles = 0;
    done      = 0;
    memreadM  = rd;
    memwriteM = wr;
    sizeM     = sz;
    signedM   = sg;
    addrM     = addr;
    wdataM    = wdata;
    if (!mis) begin
      expTxn++;
      if (rd) expRd = modelLoad(rdata, sz, sg, addr);
    end
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (c == 0) checkVal("misalign", misalignM, mis);
      if (stallM) stallCnt++;
      if (bus_req) begin
        reqCycles++;
        checkVal("busCtl", {bus_we, bus_be, bus_addr},
                 {wr & ~rd, modelBe(sz, addr), addr & 32'hFFFF_FFFC});
        if (wr && !rd) checkVal("busWdata", bus_wdata, modelWdata(sz, wdata));
        if (reqCycles == waits + 1) begin
          bus_ack   = 1'b1;
          bus_rdata = rdata;
        end
      end
      if (!stallM) begin
        done = 1;
        checkVal("readdata", readdataM, expRd);
        checkVal("busErr", bus_err, 1'b0);
        if (!mis) bus_ack = 1'($urandom_range(0, 1));  // stray ack during DONE
      end
      @(posedge clk);
      #1;
      bus_ack   = 1'b0;
      bus_rdata = $urandom;
    end
    if (!done) checkVal("accessBound", 1'b0, 1'b1);
    checkVal("stallCycles", stallCnt, mis ? 0 : waits + 2);
    checkVal("reqCycles", reqCycles, mis ? 0 : waits + 1);
    memreadM  = 1'b0;
    memwriteM = 1'b0;
  endtask

  // No access; stray acks must be ignored and the bus must stay quiet.
  task automatic idle(input int n);
    memreadM  = 1'b0;
    memwriteM = 1'b0;
    addrM     = $urandom;
    for (int i = 0; i < n; i++) begin
      bus_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      checkVal("idleQuiet", {bus_req, stallM, misalignM, bus_err}, 4'b0000);
      @(posedge clk);
      #1;
    end
    bus_ack = 1'b0;
  endtask

  initial begin
    int          r0, kind, n, waits;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic        rd, wr;

    rst = 1'b1;
    memreadM = 1'b0; memwriteM = 1'b0; sizeM = 2'b00; signedM = 1'b0;
    addrM = 32'h0; wdataM = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
    expRd = 32'h0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkVal("rstCtl", {bus_req, bus_we, bus_be, bus_err, stallM}, 8'h00);
    checkVal("rstAddr", bus_addr, 32'h0);
    checkVal("rstWdata", bus_wdata, 32'h0);
    checkVal("rstRdata", readdataM, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Directed cases
    doAccess(1, 0, 2'b10, 0, 32'h100, $urandom, 32'hDEADBEEF, 0);
    doAccess(1, 0, 2'b00, 1, 32'h103, $urandom, 32'h80112233, 3);
    doAccess(1, 0, 2'b00, 0, 32'h103, $urandom, 32'h80112233, 3);
    doAccess(0, 1, 2'b01, 0, 32'h0A, 32'h1234ABCD, $urandom, 1);
    doAccess(1, 0, 2'b10, 0, 32'h102, $urandom, $urandom, 0);
    doAccess(1, 1, 2'b11, 0, 32'h44, $urandom, 32'h0BAD_F00D, 2);
    idle(2);

    // Back-to-back load then store
    r0 = reqRises;
    doAccess(1, 0, 2'b01, 1, 32'h202, $urandom, 32'h8765_4321, 0);
    doAccess(0, 1, 2'b00, 0, 32'h301, 32'h0000_00A5, $urandom, 0);
    idle(3);
    checkVal("b2bTxn", reqRises - r0, 2);

    // Reset while BUSY, then stray acks
    memreadM = 1'b1; memwriteM = 1'b0; sizeM = 2'b10; addrM = 32'h400;
    expTxn++;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    memreadM = 1'b0;
    #1;
    checkVal("rstBusyReq", {bus_req, stallM}, 2'b00);
    expRd = 32'h0;
    @(posedge clk);
    #1 bus_ack = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 bus_ack = 1'b0;
    @(negedge clk);
    checkVal("rstAfterAck", {bus_req, stallM, bus_err}, 3'b000);
    checkVal("rstAfterRdata", readdataM, 32'h0);
    @(posedge clk);
    #1;
    doAccess(1, 0, 2'b00, 1, 32'h502, $urandom, 32'h00C3_0000, 1);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      kind  = $urandom_range(0, 7);
      sz    = 2'($urandom_range(0, 3));
      n     = nBytes(sz);
      addr  = $urandom;
      waits = $urandom_range(0, 3);
      if (kind != 7) addr = addr - (addr % n);
      rd = (kind < 3) || (kind == 6);
      wr = ((kind >= 3) && (kind < 6)) || (kind == 6);
      if (kind == 7) begin
        rd = 1'($urandom_range(0, 1));
        wr = ~rd;
      end
      doAccess(rd, wr, sz, 1'($urandom_range(0, 1)), addr, $urandom, $urandom, waits);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end

`ifdef MEM_TIMEOUT_EN
    begin
      int  stallCnt, reqCycles;
      bit  done;
      doAccess(1, 0, 2'b10, 0, 32'h600, $urandom, 32'hCAFE_F00D, 0);
      memreadM = 1'b1; memwriteM = 1'b0; sizeM = 2'b10; signedM = 1'b0; addrM = 32'h200;
      expTxn++;
      expRd = 32'h0;
      stallCnt = 0; reqCycles = 0; done = 0;
      for (int c = 0; c < 20 && !done; c++) begin
        @(negedge clk);
        if (stallM) stallCnt++;
        if (bus_req) reqCycles++;
        if (!stallM) begin
          done = 1;
          checkVal("toErr", bus_err, 1'b1);
          checkVal("toRdata", readdataM, 32'h0);
        end
        @(posedge clk);
        #1;
      end
      memreadM = 1'b0;
      checkVal("toBound", done, 1'b1);
      checkVal("toStall", stallCnt, 5);
      checkVal("toReq", reqCycles, 4);
      @(negedge clk);
      checkVal("toErrOnce", bus_err, 1'b0);
      @(posedge clk);
      #1;
    end
`endif

    idle(2);
    checkVal("txnTotal", reqRises, expTxn);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
